// File: rtl/decap_seq_pkg.sv
// Shared types and helpers for the decap bank sequencer and its sub-blocks.
package decap_seq_pkg;

    // Widest bank any sequencer in this family may drive.
    localparam int NSEG_MAX = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } seqState_e;

    // Width needed to hold a segment count of 0..nseg inclusive.
    function automatic int cnt_width(input int nseg);
        return $clog2(nseg + 1);
    endfunction

    // Thermometer code: bit i is set iff i < count.
    function automatic logic [NSEG_MAX-1:0] therm(input int count);
        logic [NSEG_MAX-1:0] t;
        for (int i = 0; i < NSEG_MAX; i++) begin
            t[i] = (i < count);
        end
        return t;
    endfunction

endpackage

// File: rtl/decap_dwell_cnt.sv
// Loadable down-counter with a zero flag; holds at zero instead of wrapping.
module decap_dwell_cnt #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] loadVal_i,
    input  logic               dec_i,
    output logic [DWELL_W-1:0] count_o,
    output logic               zero_o
);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    // Load has priority over decrement; decrement saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - DWELL_W'(1);
        end
    end

    // Counter register, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/decap_bank_seq.sv
// Decap/MOM bank sequencer: walks a thermometer enable vector toward a
// requested segment count one segment at a time, with a programmable dwell
// between steps to limit rail di/dt. Optional macro DECAP_SEQ_FAST_OFF_EN
// adds a fast_off input that drops every segment in one cycle.
module decap_bank_seq
    import decap_seq_pkg::*;
#(
    parameter int NSEG    = 8,
    parameter int DWELL_W = 8,
    parameter int CNT_W   = cnt_width(NSEG)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CNT_W-1:0]   req_target,
    input  logic [DWELL_W-1:0] dwell,
    output logic [NSEG-1:0]    seg_en,
    output logic [CNT_W-1:0]   cur_count,
    output logic               busy,
    output logic               done
`ifdef DECAP_SEQ_FAST_OFF_EN
    ,
    input  logic               fast_off
`endif
);

    localparam logic [CNT_W-1:0] NSEG_C = CNT_W'(NSEG);

    seqState_e          state_q, state_d;
    logic [CNT_W-1:0]   curCount_q, curCount_d;
    logic [CNT_W-1:0]   tgt_q, tgt_d;
    logic [DWELL_W-1:0] dwl_q, dwl_d;
    logic [NSEG-1:0]    segEn_q;
    logic [CNT_W-1:0]   reqTgt;
    logic               dwellLoad;
    logic               dwellDec;
    logic [DWELL_W-1:0] dwellCnt;
    logic               dwellZero;
    logic               dwellLast;
    logic               fastOff;

`ifdef DECAP_SEQ_FAST_OFF_EN
    assign fastOff = fast_off;
`else
    assign fastOff = 1'b0;
`endif

    decap_dwell_cnt #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk       (clk),
        .rst       (rst),
        .load_i    (dwellLoad),
        .loadVal_i (dwl_q),
        .dec_i     (dwellDec),
        .count_o   (dwellCnt),
        .zero_o    (dwellZero)
    );

    // The last WAIT cycle is the one where the counter reads 1; zero is a
    // safety net so WAIT can never stall.
    assign dwellLast = dwellZero || (dwellCnt == DWELL_W'(1));

    // Requests beyond the bank size saturate to a fully enabled bank.
    assign reqTgt = (req_target > NSEG_C) ? NSEG_C : req_target;

    // Next-state logic: one segment per STEP, dwell between steps, fast-off overrides all.
    always_comb begin
        state_d    = state_q;
        curCount_d = curCount_q;
        tgt_d      = tgt_q;
        dwl_d      = dwl_q;
        dwellLoad  = 1'b0;
        dwellDec   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tgt_d   = reqTgt;
                    dwl_d   = dwell;
                    state_d = (reqTgt == curCount_q) ? DONE : STEP;
                end
            end
            STEP: begin
                if (tgt_q > curCount_q) begin
                    curCount_d = curCount_q + CNT_W'(1);
                end else begin
                    curCount_d = curCount_q - CNT_W'(1);
                end
                dwellLoad = 1'b1;
                if (dwl_q != '0) begin
                    state_d = WAIT;
                end else if (curCount_d == tgt_q) begin
                    state_d = DONE;
                end else begin
                    state_d = STEP;
                end
            end
            WAIT: begin
                dwellDec = 1'b1;
                if (dwellLast) begin
                    state_d = (curCount_q != tgt_q) ? STEP : DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (fastOff) begin
            curCount_d = '0;
            tgt_d      = '0;
            state_d    = DONE;
        end
    end

    // State and datapath registers; reset drops every segment at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            curCount_q <= '0;
            tgt_q      <= '0;
            dwl_q      <= '0;
            segEn_q    <= '0;
        end else begin
            state_q    <= state_d;
            curCount_q <= curCount_d;
            tgt_q      <= tgt_d;
            dwl_q      <= dwl_d;
            segEn_q    <= NSEG'(therm(int'(curCount_d)));
        end
    end

    assign seg_en    = segEn_q;
    assign cur_count = curCount_q;
    assign busy      = (state_q != IDLE);
    assign req_ready = (state_q == IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_decap_bank_seq.sv
// Bench for decap_bank_seq: table of ramp requests plus hand-written
// back-pressure, reset and (with DECAP_SEQ_FAST_OFF_EN) fast-off sequences.
module tb_decap_bank_seq;

    localparam int NSEG    = 8;
    localparam int DWELL_W = 8;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [CNT_W-1:0]   req_target = '0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [NSEG-1:0]    seg_en;
    logic [CNT_W-1:0]   cur_count;
    logic               busy;
    logic               done;
`ifdef DECAP_SEQ_FAST_OFF_EN
    logic               fast_off = 1'b0;
`endif

    typedef struct {
        int         target;
        int         dwl;
        int         expCount;
        logic [7:0] expSegEn;
        int         expLat;
    } vec_t;

    typedef struct {
        int         expCount;
        logic [7:0] expSegEn;
        int         expLat;
        int         dwl;
    } exp_t;

    vec_t vecs[7];
    exp_t sbQ[$];

    int errors = 0;
    int checks = 0;
    int modelCount = 0;
    bit holdValid = 1'b0;
    int holdTarget = 0;
    int holdDwell = 0;

    decap_bank_seq #(
        .NSEG    (NSEG),
        .DWELL_W (DWELL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_target (req_target),
        .dwell      (dwell),
        .seg_en     (seg_en),
        .cur_count  (cur_count),
        .busy       (busy),
        .done       (done)
`ifdef DECAP_SEQ_FAST_OFF_EN
        ,
        .fast_off   (fast_off)
`endif
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one request at a negedge once the DUT is ready and record what it should produce.
    task automatic applyStimulus(input int target, input int dwl, input int expCount,
                                 input logic [7:0] expSegEn, input int expLat);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) checkOutput("ready_timeout", int'(req_ready), 1);
        req_valid  = 1'b1;
        req_target = CNT_W'(target);
        dwell      = DWELL_W'(dwl);
        sbQ.push_back('{expCount, expSegEn, expLat, dwl});
        @(posedge clk);
    endtask

    // Watch the ramp after an accept edge until done, then compare against the scoreboard.
    task automatic runUntilDone();
        int n = 0;
        int prevCount = modelCount;
        int lastChange = 0;
        int badTherm = 0;
        int badStep = 0;
        int badMono = 0;
        int badReady = 0;
        int delta;
        int dwl;
        bit seen = 1'b0;
        logic [7:0] model;
        exp_t e;
        dwl = (sbQ.size() > 0) ? sbQ[0].dwl : 0;
        while (!seen && n < 400) begin
            @(negedge clk);
            n++;
            if (holdValid) begin
                req_target = CNT_W'(holdTarget);
                dwell      = DWELL_W'(holdDwell);
                if (req_ready) badReady++;
            end else begin
                req_valid = 1'b0;
                dwell     = DWELL_W'($urandom_range(0, 255));
            end
            model = 8'((16'h1 << cur_count) - 16'h1);
            if (seg_en != model) badTherm++;
            delta = int'(cur_count) - prevCount;
            if (delta != 0) begin
                if (delta != 1 && delta != -1) badMono++;
                if (lastChange == 0) begin
                    if (n != 2) badStep++;
                end else if ((n - lastChange) != dwl + 1) begin
                    badStep++;
                end
                lastChange = n;
            end
            prevCount = int'(cur_count);
            if (done) seen = 1'b1;
        end
        if (!seen) checkOutput("done_timeout", int'(done), 1);
        if (sbQ.size() == 0) begin
            checkOutput("scoreboard_empty", 0, 1);
        end else begin
            e = sbQ.pop_front();
            checkOutput("final_count", int'(cur_count), e.expCount);
            checkOutput("final_seg_en", int'(seg_en), int'(e.expSegEn));
            checkOutput("done_latency", n, e.expLat);
            modelCount = e.expCount;
        end
        checkOutput("thermometer_violations", badTherm, 0);
        checkOutput("step_timing_violations", badStep, 0);
        checkOutput("multi_bit_steps", badMono, 0);
        if (holdValid) checkOutput("bp_ready_high_while_busy", badReady, 0);
        @(negedge clk);
        checkOutput("done_one_cycle", int'(done), 0);
        checkOutput("ready_after_done", int'(req_ready), 1);
        checkOutput("idle_after_done", int'(busy), 0);
    endtask

    initial begin
        int waited;

        vecs[0] = '{4, 2, 4, 8'h0F, 13};
        vecs[1] = '{1, 0, 1, 8'h01, 4};
        vecs[2] = '{15, 1, 8, 8'hFF, 15};
        vecs[3] = '{8, 3, 8, 8'hFF, 1};
        vecs[4] = '{0, 0, 0, 8'h00, 9};
        vecs[5] = '{3, 5, 3, 8'h07, 19};
        vecs[6] = '{2, 1, 2, 8'h03, 3};

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("reset_seg_en", int'(seg_en), 0);
        checkOutput("reset_cur_count", int'(cur_count), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_done", int'(done), 0);
        checkOutput("reset_ready", int'(req_ready), 1);
        rst = 1'b0;

        // Table-driven ramps, each starting where the previous one ended
        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d: target=%0d dwell=%0d", i, vecs[i].target, vecs[i].dwl);
            applyStimulus(vecs[i].target, vecs[i].dwl, vecs[i].expCount, vecs[i].expSegEn, vecs[i].expLat);
            runUntilDone();
        end

        // Back-pressure: a second request held through a ramp from 2 up to 6
        $display("[TB] back-pressure sequence");
        holdTarget = 2;
        holdDwell  = 0;
        holdValid  = 1'b1;
        applyStimulus(6, 1, 6, 8'h3F, 9);
        runUntilDone();
        holdValid = 1'b0;
        sbQ.push_back('{2, 8'h03, 5, 0});
        @(posedge clk);
        runUntilDone();

        // Reset asserted in WAIT right after stepping to 3
        $display("[TB] reset mid-ramp sequence");
        @(negedge clk);
        req_valid  = 1'b1;
        req_target = 4'd7;
        dwell      = 8'd3;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        waited = 0;
        while (cur_count != 4'd3 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("midramp_count", int'(cur_count), 3);
        checkOutput("midramp_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst_mid_seg_en", int'(seg_en), 0);
        checkOutput("rst_mid_busy", int'(busy), 0);
        checkOutput("rst_mid_ready", int'(req_ready), 1);
        checkOutput("rst_mid_done", int'(done), 0);
        checkOutput("rst_mid_count", int'(cur_count), 0);
        modelCount = 0;

`ifdef DECAP_SEQ_FAST_OFF_EN
        // Fast-off at count 6 during a ramp to 8
        $display("[TB] fast-off sequence");
        @(negedge clk);
        req_valid  = 1'b1;
        req_target = 4'd8;
        dwell      = 8'd1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        waited = 0;
        while (cur_count != 4'd6 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("fo_pre_count", int'(cur_count), 6);
        fast_off = 1'b1;
        @(negedge clk);
        fast_off = 1'b0;
        checkOutput("fo_seg_en", int'(seg_en), 0);
        checkOutput("fo_count", int'(cur_count), 0);
        checkOutput("fo_done", int'(done), 1);
        @(negedge clk);
        checkOutput("fo_done_drop", int'(done), 0);
        checkOutput("fo_ready", int'(req_ready), 1);
        // Fast-off coinciding with an accept: the request is dropped
        req_valid  = 1'b1;
        req_target = 4'd5;
        dwell      = 8'd0;
        fast_off   = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        fast_off  = 1'b0;
        checkOutput("fo_acc_done", int'(done), 1);
        checkOutput("fo_acc_count", int'(cur_count), 0);
        @(negedge clk);
        checkOutput("fo_acc_idle", int'(busy), 0);
        checkOutput("fo_acc_count2", int'(cur_count), 0);
        checkOutput("fo_acc_seg_en", int'(seg_en), 0);
        modelCount = 0;
`endif

        // Recovery ramp from zero after the disruptive sequences
        $display("[TB] recovery ramp");
        applyStimulus(3, 0, 3, 8'h07, 4);
        runUntilDone();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
